// File: rtl/result_sched_pkg.sv
// Shared types and constants for the result scheduler.
// Optional feature macro: RESULT_SCHED_CKSUM_EN adds a checksum beat (state CK).
package result_sched_pkg;

   localparam int NUM_REQ = 2;
   localparam int BYTE_W  = 8;

   localparam logic [1:0] TAG_IDLE = 2'b00;
   localparam logic [1:0] TAG_REQ0 = 2'b10;
   localparam logic [1:0] TAG_REQ1 = 2'b11;

`ifdef RESULT_SCHED_CKSUM_EN
   typedef enum logic [1:0] {IDLE, HI, LO, CK} state_e;
`else
   typedef enum logic [1:0] {IDLE, HI, LO} state_e;
`endif

   // Beat tag for a given source id: 2'b10 for requester 0, 2'b11 for requester 1.
   function automatic logic [1:0] beat_tag(input logic id);
      return id ? TAG_REQ1 : TAG_REQ0;
   endfunction

endpackage

// File: rtl/result_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, favours the requester not served last.
module rr_arb2
   import result_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic               last_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] grant_o
);

   // Grant the lone requester, or on contention the one that did not win last time.
   always_comb begin
      grant_o = '0;
      if (en_i) begin
         case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/result_sched.sv
// Result scheduler: accepts 16-bit results from two requesters and serialises
// each into tagged byte beats on a registered 10-bit output.
// Optional feature macro: RESULT_SCHED_CKSUM_EN appends an XOR checksum beat.
module result_sched
   import result_sched_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   input  logic [15:0] req_ans0,
   input  logic [15:0] req_ans1,
   output logic [1:0]  req_ready,
   output logic [9:0]  out,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [15:0] ans_q, ans_d;
   logic        id_q, id_d;
   logic        last_q, last_d;
   logic [9:0]  out_q, out_d;

   logic [1:0]  grant;
   logic        final_beat;
   logic        accept_en;
   logic        xfer;
   logic        win_id;
   logic [15:0] sel_ans;

`ifdef RESULT_SCHED_CKSUM_EN
   assign final_beat = (state_q == CK);
`else
   assign final_beat = (state_q == LO);
`endif

   // A new word is accepted only when idle or while the last beat is on the wire;
   // reset_n gates it so nothing is offered while reset is held.
   assign accept_en = reset_n && ((state_q == IDLE) || final_beat);

   rr_arb2 u_arb (
      .valid_i (req_valid),
      .last_i  (last_q),
      .en_i    (accept_en),
      .grant_o (grant)
   );

   assign xfer      = |grant;
   assign win_id    = grant[1];
   assign sel_ans   = win_id ? req_ans1 : req_ans0;
   assign req_ready = grant;
   assign out       = out_q;
   assign busy      = (state_q != IDLE);

   // Next-state and next-beat logic; the beat shown next cycle is computed here.
   always_comb begin
      state_d = state_q;
      ans_d   = ans_q;
      id_d    = id_q;
      last_d  = last_q;
      out_d   = {{BYTE_W{1'b0}}, TAG_IDLE};
      if (xfer) begin
         ans_d   = sel_ans;
         id_d    = win_id;
         last_d  = win_id;
         state_d = HI;
         out_d   = {sel_ans[15:8], beat_tag(win_id)};
      end else begin
         case (state_q)
            HI: begin
               state_d = LO;
               out_d   = {ans_q[7:0], beat_tag(id_q)};
            end
`ifdef RESULT_SCHED_CKSUM_EN
            LO: begin
               state_d = CK;
               out_d   = {ans_q[15:8] ^ ans_q[7:0], beat_tag(id_q)};
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   // State, holding register and output beat; reset aborts any transaction at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ans_q   <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         ans_q   <= ans_d;
         id_q    <= id_d;
         last_q  <= last_d;
         out_q   <= out_d;
      end
   end

endmodule

// File: tb/tb_result_sched.sv
// Self-checking bench for result_sched: a reference model predicts grants and
// pushes expected beats to a scoreboard queue that is popped each cycle.
module tb_result_sched;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [15:0] req_ans0;
   logic [15:0] req_ans1;
   wire  [1:0]  req_ready;
   wire  [9:0]  out;
   wire         busy;

   int          errors = 0;
   int          checks = 0;
   logic [9:0]  exp_q[$];
   logic        m_last;

   result_sched dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ans0  (req_ans0),
      .req_ans1  (req_ans1),
      .req_ready (req_ready),
      .out       (out),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check grant, predict beats, check output after the edge.
   task automatic cycle(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] a1);
      logic [1:0]  g;
      logic        id;
      logic [15:0] a;
      logic [9:0]  e;
      logic        eb;
      req_valid = v;
      req_ans0  = a0;
      req_ans1  = a1;
      #1;
      g = 2'b00;
      if (exp_q.size() == 0) begin
         if (v == 2'b11) g = m_last ? 2'b01 : 2'b10;
         else            g = v;
      end
      chk("req_ready", {14'd0, req_ready}, {14'd0, g});
      if (g != 2'b00) begin
         id = g[1];
         a  = id ? a1 : a0;
         exp_q.push_back({a[15:8], 1'b1, id});
         exp_q.push_back({a[7:0], 1'b1, id});
`ifdef RESULT_SCHED_CKSUM_EN
         exp_q.push_back({a[15:8] ^ a[7:0], 1'b1, id});
`endif
         m_last = id;
         $display("xfer: req%0d ans=%h", id, a);
      end
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         eb = 1'b1;
      end else begin
         e  = 10'd0;
         eb = 1'b0;
      end
      chk("out", {6'd0, out}, {6'd0, e});
      chk("busy", {15'd0, busy}, {15'd0, eb});
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 2'b01;
      req_ans0  = 16'hA55A;
      req_ans1  = 16'h0000;
      m_last    = 1'b1;
      #2;
      chk("rst_out", {6'd0, out}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_ready", {14'd0, req_ready}, 16'd0);
      req_valid = 2'b00;
      #6 reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Single request, then holding register must ignore input changes.
      cycle(2'b01, 16'hA55A, 16'h0000);
      chk("single_hi", {6'd0, out}, 16'h0296);
      cycle(2'b00, 16'h0000, 16'h0000);
      cycle(2'b00, 16'h0000, 16'h0000);
      cycle(2'b00, 16'h0000, 16'h0000);

      // Contention: alternating grants with gapless beats.
      for (int i = 0; i < 8; i++) cycle(2'b11, 16'h1234, 16'hBEEF);
      for (int i = 0; i < 3; i++) cycle(2'b00, 16'h1234, 16'hBEEF);

      // Back-to-back from requester 1 with changing data.
      for (int i = 0; i < 6; i++) cycle(2'b10, 16'h0000, 16'h1000 + 16'(i * 16'h0111));
      for (int i = 0; i < 3; i++) cycle(2'b00, 16'h0000, 16'h0000);

      // Withdrawn request: pulse during HI only.
      cycle(2'b10, 16'h0000, 16'h7777);
      cycle(2'b01, 16'h2222, 16'h0000);
      cycle(2'b00, 16'h2222, 16'h0000);
      cycle(2'b00, 16'h2222, 16'h0000);
      cycle(2'b00, 16'h2222, 16'h0000);

      // Reset mid-transaction (during HI).
      cycle(2'b01, 16'hC3C3, 16'h0000);
      req_valid = 2'b01;
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_out", {6'd0, out}, 16'd0);
      chk("midrst_busy", {15'd0, busy}, 16'd0);
      chk("midrst_ready", {14'd0, req_ready}, 16'd0);
      exp_q.delete();
      m_last = 1'b1;
      req_valid = 2'b00;
      @(posedge clock);
      #1;
      chk("midrst_hold", {6'd0, out}, 16'd0);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("postrst_out", {6'd0, out}, 16'd0);
      cycle(2'b00, 16'h0000, 16'h0000);
      cycle(2'b00, 16'h0000, 16'h0000);
      // After reset requester 0 must win first under contention.
      cycle(2'b11, 16'h1234, 16'hBEEF);
      for (int i = 0; i < 4; i++) cycle(2'b00, 16'h0000, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_sched.md
RESULT_SCHED -- requirements
Module: result_sched

Interface
REQ-001 The block SHALL have these ports, with clock and reset first:
- clock      input   1    single rising-edge clock
- reset_n    input   1    asynchronous, active-low reset
- req_valid  input   2    per requester: result word pending
- req_ans0   input   16   requester 0 result
- req_ans1   input   16   requester 1 result
- req_ready  output  2    per requester: accept strobe (combinational)
- out        output  10   [9:2] data byte, [1:0] beat tag
- busy       output  1    a transaction is in flight
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.

Function
REQ-003 Transfer SHALL occur on a rising edge where req_valid[i] && req_ready[i]; on that edge the block latches the matching req_ans into a 16-bit holding register and latches the source id.
REQ-004 At most one req_ready bit SHALL be high per cycle.
REQ-005 req_ready SHALL be high only in state IDLE or on the final beat of a transaction, and only for the arbitration winner.
REQ-006 Arbitration SHALL be round-robin:
- one requester valid -> that requester wins;
- both valid -> the requester not served last wins;
- the last-served pointer updates only on a transfer.
REQ-007 The FSM SHALL use the states IDLE, HI, LO, and CK (CK only under REQ-014), with these transitions:
- IDLE -> HI on a transfer;
- HI -> LO unconditionally;
- LO (or CK when present) -> HI on a transfer that cycle, otherwise -> IDLE.
REQ-008 out SHALL be registered:
- in the cycle after a transfer: out = {ans[15:8], 2'b10 | id};
- in the next cycle: out = {ans[7:0], 2'b10 | id}.
REQ-009 Tag encoding SHALL be:
- 2'b00 = idle;
- 2'b10 = requester 0 beat;
- 2'b11 = requester 1 beat;
- 2'b01 is never driven.
REQ-010 In IDLE, out SHALL be 10'd0.
REQ-011 busy SHALL be high in HI, LO, and CK, and low in IDLE.
REQ-012 Back-to-back transfers SHALL produce gapless beats; the latency from transfer edge to first beat SHALL be 1 cycle.
REQ-013 req_valid that deasserts before a transfer SHALL be dropped with no effect, and the holding register SHALL change only on a transfer.

Reset
REQ-014 (moved to Configuration; number reserved for CK) -- see REQ-016.
REQ-015 While reset_n is low, the block SHALL hold:
- state = IDLE;
- out = 0;
- busy = 0;
- req_ready = 0;
- holding register = 0;
- last-served pointer = 1, so requester 0 wins first.
Reset asserted mid-transaction SHALL abort it with no remaining beats emitted.

Configuration
REQ-016 With RESULT_SCHED_CKSUM_EN defined:
- state CK SHALL follow LO;
- CK SHALL emit out = {ans[15:8] ^ ans[7:0], 2'b10 | id};
- the final beat SHALL be CK.
Without the macro, CK SHALL not exist and LO SHALL be the final beat.

Structure
REQ-017 A shared package result_sched_pkg SHALL hold:
- the state enum;
- the tag constants TAG_IDLE, TAG_REQ0, TAG_REQ1;
- NUM_REQ = 2;
- BYTE_W = 8.
REQ-018 Round-robin selection SHALL live in the sub-module rr_arb2, which takes the valid bits, the last-served pointer, and an enable, and returns a one-hot grant.

Verification
REQ-019 Single request: req_valid = 2'b01, req_ans0 = 16'hA55A, held one cycle -> out = 10'h296 then 10'h16A, then 10'h000; busy is high for 2 cycles.
REQ-020 Contention: both valid continuously with req_ans0 = 16'h1234 and req_ans1 = 16'hBEEF -> grants alternate 0,1,0,1; out carries {12,34} tag 10, then {BE,EF} tag 11, with no idle gap.
REQ-021 Back-to-back same requester: req_valid[1] held high -> req_ready[1] pulses on every LO beat, and the beats are continuous.
REQ-022 Reset mid-transaction: reset_n driven low during HI -> out = 0 and busy = 0 immediately (asynchronous), and no LO beat appears after release.
REQ-023 Checksum build: RESULT_SCHED_CKSUM_EN defined, req_ans0 = 16'h0FF0 -> beats 0F, F0, FF, each with tag 10.
REQ-024 Withdrawn request: req_valid[0] pulsed while in HI and dropped before LO -> no req_ready, and no transfer occurs.
